// File: rtl/seven_seg_scanner_pkg.sv
// Display definitions shared by the scanner and its segment decoder: glyphs,
// digit slot indices, the frame snapshot record and the active-low 0-F table.
package seven_seg_scanner_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_H     = 7'b0001011;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;
  localparam logic [1:0] DIG_MODE = 2'd3;

  typedef struct packed {
    logic [8:0] value;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       hex_mode;
  } snap_t;

  // Segments are {g,f,e,d,c,b,a}, a zero lights the segment.
  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_hex_to_7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_7seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_of(nibble);

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed display driver: three value digits (decimal or hex)
// plus a mode glyph, refreshed one slot at a time with a blank guard per slot.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int LZ_BLANK     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] value,
  input  logic [3:0] hund,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       hex_mode,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // One extra bit so the guard threshold stays representable when BLANK_CYCLES is 0.
  localparam int CNT_W = $clog2(REFRESH_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_START = CNT_W'(REFRESH_DIV - BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;
  snap_t            snap_reg, snap_next;
  logic             load_pending_reg, load_pending_next;
  logic [3:0]       an_reg, an_next;
  logic [6:0]       seg_reg, seg_next;

  logic       terminal;
  logic       guard;
  logic [3:0] an_sel;
  logic [3:0] nibble;
  logic [6:0] nibble_seg;
  logic       blank_digit;
  logic       dash_digit;
  logic       glyph_digit;

  assign terminal = (cnt_reg == CNT_LAST);
  assign guard    = (cnt_reg >= GUARD_START);

  always_comb begin
    cnt_next          = terminal ? '0 : cnt_reg + CNT_W'(1);
    idx_next          = terminal ? idx_reg + 2'd1 : idx_reg;
    load_pending_next = 1'b0;
    snap_next         = snap_reg;
    // Latching only at the frame boundary keeps all four digits from one sample.
    if (load_pending_reg || (terminal && idx_reg == DIG_MODE)) begin
      snap_next.value    = value;
      snap_next.hund     = hund;
      snap_next.tens     = tens;
      snap_next.ones     = ones;
      snap_next.hex_mode = hex_mode;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_anode
      assign an_sel[gi] = (idx_reg == 2'(gi));
    end
  endgenerate

  always_comb begin
    nibble      = 4'h0;
    blank_digit = 1'b0;
    dash_digit  = 1'b0;
    glyph_digit = 1'b0;
    case (idx_reg)
      DIG_ONES: begin
        nibble     = snap_reg.hex_mode ? snap_reg.value[3:0] : snap_reg.ones;
        dash_digit = !snap_reg.hex_mode && (snap_reg.ones > 4'd9);
      end
      DIG_TENS: begin
        nibble      = snap_reg.hex_mode ? snap_reg.value[7:4] : snap_reg.tens;
        blank_digit = !snap_reg.hex_mode && (LZ_BLANK != 0) &&
                      (snap_reg.hund == 4'd0) && (snap_reg.tens == 4'd0);
        dash_digit  = !snap_reg.hex_mode && (snap_reg.tens > 4'd9);
      end
      DIG_HUND: begin
        nibble      = snap_reg.hex_mode ? {3'b000, snap_reg.value[8]} : snap_reg.hund;
        blank_digit = !snap_reg.hex_mode && (LZ_BLANK != 0) && (snap_reg.hund == 4'd0);
        dash_digit  = !snap_reg.hex_mode && (snap_reg.hund > 4'd9);
      end
      default: glyph_digit = 1'b1;
    endcase
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble),
    .seg    (nibble_seg)
  );

  // Blanking wins over the invalid-BCD dash; the guard window wins over everything.
  always_comb begin
    an_next = guard ? 4'hF : ~an_sel;
    if (guard)            seg_next = SEG_BLANK;
    else if (glyph_digit) seg_next = snap_reg.hex_mode ? SEG_H : SEG_D;
    else if (blank_digit) seg_next = SEG_BLANK;
    else if (dash_digit)  seg_next = SEG_DASH;
    else                  seg_next = nibble_seg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg          <= '0;
      idx_reg          <= DIG_ONES;
      snap_reg         <= '0;
      load_pending_reg <= 1'b1;
      an_reg           <= 4'hF;
      seg_reg          <= SEG_BLANK;
    end else begin
      cnt_reg          <= cnt_next;
      idx_reg          <= idx_next;
      snap_reg         <= snap_next;
      load_pending_reg <= load_pending_next;
      an_reg           <= an_next;
      seg_reg          <= seg_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = 1'b1;

endmodule
